// File: rtl/hazard_ctrl_pipe.sv
// Hazard, stall and flush controller for the 5-stage F/D/E/M/W core.
// Forwarding and stall/flush decisions are combinational; a small FSM tracks divides and deferred exceptions.
module hazard_ctrl_pipe #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned DIV_CYCLES = 32,
    parameter logic [31:0] EXC_VEC    = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE  = 32'h0000000e
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rtD,
    input  logic [REG_W-1:0] rsE,
    input  logic [REG_W-1:0] rtE,
    input  logic [REG_W-1:0] rdE,
    input  logic [REG_W-1:0] writeregE,
    input  logic [REG_W-1:0] writeregM,
    input  logic [REG_W-1:0] writeregW,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             hilo_writeM,
    input  logic             hilo_writeW,
    input  logic             cp0_writeM,
    input  logic             cp0_writeW,
    input  logic             div_startE,
    input  logic [31:0]      excepttype,
    input  logic [31:0]      cp0_epc,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_mem,
    output logic [1:0]       forwardaD,
    output logic [1:0]       forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic [1:0]       forwardHiLoE,
    output logic [1:0]       forwardCP0E,
    output logic             div_busy,
    output logic             div_done,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             stallW,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             flush_exc,
    output logic [31:0]      newpc
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV      = 2'd1,
        ST_EXC_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        exc_code_q, exc_code_d;
    logic [31:0]        exc_epc_q, exc_epc_d;

    logic               exc_live;
    logic               exc_wait;
    logic               lw_e;
    logic               lw_m;
    logic               lwstall;
    logic               busy_int;
    logic               flush_int;
    logic               stall_e_int;

    // A new exception is only observed outside EXC_WAIT; there the latched copy is used.
    assign exc_live    = (excepttype != 32'd0) && (state_q != ST_EXC_WAIT);
    assign exc_wait    = (state_q == ST_EXC_WAIT);
    assign busy_int    = (state_q == ST_DIV) && (cnt_q != '0);
    assign flush_int   = !stallreq_from_mem && (exc_live || exc_wait);
    assign stall_e_int = busy_int || stallreq_from_mem || exc_wait;

    assign lw_e = memtoregE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD));
    assign lw_m = (LOAD_LAT == 32'd2) && memtoregM && (writeregM != '0)
                  && ((writeregM == rsD) || (writeregM == rtD));
    assign lwstall = lw_e || lw_m;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            exc_code_q <= 32'd0;
            exc_epc_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exc_code_q <= exc_code_d;
            exc_epc_q  <= exc_epc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        exc_code_d = exc_code_q;
        exc_epc_d  = exc_epc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (exc_live) begin
                    if (stallreq_from_mem) begin
                        state_d    = ST_EXC_WAIT;
                        exc_code_d = excepttype;
                        exc_epc_d  = cp0_epc;
                    end
                end else if (div_startE) begin
                    state_d = ST_DIV;
                    cnt_d   = CNT_W'(DIV_CYCLES - 1);
                end
            end
            ST_DIV: begin
                if (exc_live) begin
                    cnt_d = '0;
                    if (stallreq_from_mem) begin
                        state_d    = ST_EXC_WAIT;
                        exc_code_d = excepttype;
                        exc_epc_d  = cp0_epc;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!stallreq_from_mem) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_EXC_WAIT: begin
                if (!stallreq_from_mem) begin
                    state_d    = ST_IDLE;
                    exc_code_d = 32'd0;
                    exc_epc_d  = 32'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic; reset forces every output low regardless of inputs
    always_comb begin
        forwardaD    = 2'b00;
        forwardbD    = 2'b00;
        forwardaE    = 2'b00;
        forwardbE    = 2'b00;
        forwardHiLoE = 2'b00;
        forwardCP0E  = 2'b00;
        div_busy     = 1'b0;
        div_done     = 1'b0;
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        stallW       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;
        flushM       = 1'b0;
        flushW       = 1'b0;
        flush_exc    = 1'b0;
        newpc        = 32'd0;
        if (!rst) begin
            if ((rsD != '0) && regwriteE && (rsD == writeregE))      forwardaD = 2'b10;
            else if ((rsD != '0) && regwriteM && (rsD == writeregM)) forwardaD = 2'b01;
            else if ((rsD != '0) && regwriteW && (rsD == writeregW)) forwardaD = 2'b11;

            if ((rtD != '0) && regwriteE && (rtD == writeregE))      forwardbD = 2'b10;
            else if ((rtD != '0) && regwriteM && (rtD == writeregM)) forwardbD = 2'b01;
            else if ((rtD != '0) && regwriteW && (rtD == writeregW)) forwardbD = 2'b11;

            if ((rsE != '0) && regwriteM && (rsE == writeregM))      forwardaE = 2'b10;
            else if ((rsE != '0) && regwriteW && (rsE == writeregW)) forwardaE = 2'b01;

            if ((rtE != '0) && regwriteM && (rtE == writeregM))      forwardbE = 2'b10;
            else if ((rtE != '0) && regwriteW && (rtE == writeregW)) forwardbE = 2'b01;

            if (hilo_writeM)      forwardHiLoE = 2'b10;
            else if (hilo_writeW) forwardHiLoE = 2'b01;

            if (cp0_writeM && (rdE == writeregM))      forwardCP0E = 2'b10;
            else if (cp0_writeW && (rdE == writeregW)) forwardCP0E = 2'b01;

            div_busy = busy_int;
            div_done = (state_q == ST_DIV) && (cnt_q == '0) && !stallreq_from_mem && !exc_live;

            if (flush_int) begin
                flush_exc = 1'b1;
                flushD    = 1'b1;
                flushE    = 1'b1;
                flushM    = 1'b1;
                flushW    = 1'b1;
                if (exc_wait) newpc = (exc_code_q == ERET_CODE) ? exc_epc_q : EXC_VEC;
                else          newpc = (excepttype == ERET_CODE) ? cp0_epc : EXC_VEC;
            end else begin
                stallF = busy_int || lwstall || stallreq_from_if || stallreq_from_mem || exc_wait;
                stallD = busy_int || lwstall || stallreq_from_if || stallreq_from_mem || exc_wait;
                stallE = stall_e_int;
                stallM = stallreq_from_mem || exc_wait;
                flushE = lwstall && !stall_e_int;
                flushW = stallreq_from_mem;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: expectations are queued as stimulus is applied
// and checked mid-cycle against two instances (load latency 1 and 2).
module tb_hazard_ctrl_pipe;

    localparam int unsigned REG_W = 5;

    localparam int S_FAD   = 0;
    localparam int S_FBD   = 1;
    localparam int S_FAE   = 2;
    localparam int S_FBE   = 3;
    localparam int S_FHL   = 4;
    localparam int S_FCP   = 5;
    localparam int S_BUSY  = 6;
    localparam int S_DONE  = 7;
    localparam int S_STALL = 8;
    localparam int S_FLUSH = 9;
    localparam int S_FEXC  = 10;
    localparam int S_NEWPC = 11;
    localparam int S_STALL2 = 12;
    localparam int S_FLUSH2 = 13;
    localparam int S_FAD2  = 14;
    localparam int S_FAE2  = 15;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] rsD, rtD, rsE, rtE, rdE, writeregE, writeregM, writeregW;
    logic             regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic             hilo_writeM, hilo_writeW, cp0_writeM, cp0_writeW, div_startE;
    logic [31:0]      excepttype, cp0_epc;
    logic             stallreq_from_if, stallreq_from_mem;

    logic [1:0]  forwardaD, forwardbD, forwardaE, forwardbE, forwardHiLoE, forwardCP0E;
    logic        div_busy, div_done, stallF, stallD, stallE, stallM, stallW;
    logic        flushD, flushE, flushM, flushW, flush_exc;
    logic [31:0] newpc;

    logic [1:0]  forwardaD2, forwardbD2, forwardaE2, forwardbE2, forwardHiLoE2, forwardCP0E2;
    logic        div_busy2, div_done2, stallF2, stallD2, stallE2, stallM2, stallW2;
    logic        flushD2, flushE2, flushM2, flushW2, flush_exc2;
    logic [31:0] newpc2;

    always #5 clk = ~clk;

    hazard_ctrl_pipe #(.REG_W(REG_W), .LOAD_LAT(1), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .rdE(rdE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .hilo_writeM(hilo_writeM), .hilo_writeW(hilo_writeW),
        .cp0_writeM(cp0_writeM), .cp0_writeW(cp0_writeW), .div_startE(div_startE),
        .excepttype(excepttype), .cp0_epc(cp0_epc),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
        .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
        .forwardHiLoE(forwardHiLoE), .forwardCP0E(forwardCP0E),
        .div_busy(div_busy), .div_done(div_done),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .flush_exc(flush_exc), .newpc(newpc)
    );

    hazard_ctrl_pipe #(.REG_W(REG_W), .LOAD_LAT(2), .DIV_CYCLES(32)) dut2 (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .rdE(rdE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .hilo_writeM(hilo_writeM), .hilo_writeW(hilo_writeW),
        .cp0_writeM(cp0_writeM), .cp0_writeW(cp0_writeW), .div_startE(div_startE),
        .excepttype(excepttype), .cp0_epc(cp0_epc),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
        .forwardaD(forwardaD2), .forwardbD(forwardbD2), .forwardaE(forwardaE2), .forwardbE(forwardbE2),
        .forwardHiLoE(forwardHiLoE2), .forwardCP0E(forwardCP0E2),
        .div_busy(div_busy2), .div_done(div_done2),
        .stallF(stallF2), .stallD(stallD2), .stallE(stallE2), .stallM(stallM2), .stallW(stallW2),
        .flushD(flushD2), .flushE(flushE2), .flushM(flushM2), .flushW(flushW2),
        .flush_exc(flush_exc2), .newpc(newpc2)
    );

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_FAD:    obs = 32'(forwardaD);
            S_FBD:    obs = 32'(forwardbD);
            S_FAE:    obs = 32'(forwardaE);
            S_FBE:    obs = 32'(forwardbE);
            S_FHL:    obs = 32'(forwardHiLoE);
            S_FCP:    obs = 32'(forwardCP0E);
            S_BUSY:   obs = 32'(div_busy);
            S_DONE:   obs = 32'(div_done);
            S_STALL:  obs = 32'({stallF, stallD, stallE, stallM, stallW});
            S_FLUSH:  obs = 32'({flushD, flushE, flushM, flushW});
            S_FEXC:   obs = 32'(flush_exc);
            S_NEWPC:  obs = newpc;
            S_STALL2: obs = 32'({stallF2, stallD2, stallE2, stallM2, stallW2});
            S_FLUSH2: obs = 32'({flushD2, flushE2, flushM2, flushW2});
            S_FAD2:   obs = 32'(forwardaD2);
            S_FAE2:   obs = 32'(forwardaE2);
            default:  obs = 32'hDEADBEEF;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    // Sample mid-cycle and drain the scoreboard
    task automatic settle();
        exp_t        e;
        logic [31:0] o;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0; rdE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0;
        hilo_writeM = 1'b0; hilo_writeW = 1'b0; cp0_writeM = 1'b0; cp0_writeW = 1'b0;
        div_startE = 1'b0; excepttype = 32'd0; cp0_epc = 32'd0;
        stallreq_from_if = 1'b0; stallreq_from_mem = 1'b0;
    endtask

    initial begin
        // Reset holds every output low even with active stall/exception inputs
        clr_inputs();
        rst = 1'b1;
        stallreq_from_mem = 1'b1;
        excepttype = 32'd1;
        push_exp("rst_stall", S_STALL, 32'h00);
        push_exp("rst_flush", S_FLUSH, 32'h0);
        push_exp("rst_fexc", S_FEXC, 32'd0);
        push_exp("rst_newpc", S_NEWPC, 32'd0);
        push_exp("rst_busy", S_BUSY, 32'd0);
        settle();
        tick();
        rst = 1'b0;
        clr_inputs();

        // Forwarding: D priority E>M>W
        rsD = 5'd3; rtD = 5'd4;
        writeregE = 5'd3; regwriteE = 1'b1;
        writeregM = 5'd4; regwriteM = 1'b1;
        writeregW = 5'd3; regwriteW = 1'b1;
        push_exp("fwdA_E", S_FAD, 32'd2);
        push_exp("fwdB_M", S_FBD, 32'd1);
        push_exp("fwd_nostall", S_STALL, 32'h00);
        settle(); tick(); clr_inputs();

        rsD = 5'd5; rtD = 5'd6;
        writeregE = 5'd0; regwriteE = 1'b1;
        writeregM = 5'd5; regwriteM = 1'b1;
        writeregW = 5'd6; regwriteW = 1'b1;
        push_exp("fwdA_M", S_FAD, 32'd1);
        push_exp("fwdB_W", S_FBD, 32'd3);
        settle(); tick(); clr_inputs();

        rsD = 5'd7; rsE = 5'd7;
        writeregM = 5'd7; regwriteM = 1'b1;
        writeregW = 5'd7; regwriteW = 1'b1;
        push_exp("fwdD_MoverW", S_FAD, 32'd1);
        push_exp("fwdE_MoverW", S_FAE, 32'd2);
        settle(); tick(); clr_inputs();

        rsE = 5'd9; rtE = 5'd9;
        writeregM = 5'd9; regwriteM = 1'b0;
        writeregW = 5'd9; regwriteW = 1'b1;
        push_exp("fwdAE_W", S_FAE, 32'd1);
        push_exp("fwdBE_W", S_FBE, 32'd1);
        settle(); tick(); clr_inputs();

        hilo_writeM = 1'b1; hilo_writeW = 1'b1;
        rdE = 5'd12; writeregM = 5'd12; cp0_writeM = 1'b1; writeregW = 5'd12; cp0_writeW = 1'b1;
        push_exp("hilo_M", S_FHL, 32'd2);
        push_exp("cp0_M", S_FCP, 32'd2);
        settle(); tick(); clr_inputs();

        hilo_writeW = 1'b1;
        rdE = 5'd12; writeregW = 5'd12; cp0_writeW = 1'b1;
        push_exp("hilo_W", S_FHL, 32'd1);
        push_exp("cp0_W", S_FCP, 32'd1);
        settle(); tick(); clr_inputs();

        // Register 0 is never forwarded and never causes a load-use stall
        regwriteE = 1'b1; memtoregE = 1'b1; writeregE = 5'd0;
        push_exp("r0_fwdA", S_FAD, 32'd0);
        push_exp("r0_fwdB", S_FBD, 32'd0);
        push_exp("r0_nostall", S_STALL, 32'h00);
        push_exp("r0_nostall2", S_STALL2, 32'h00);
        push_exp("r0_noflush", S_FLUSH, 32'h0);
        settle(); tick(); clr_inputs();

        // Load-use: lw $2 in E, consumer in D
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd2; rsD = 5'd2;
        push_exp("lw1_stall", S_STALL, 32'h18);
        push_exp("lw1_flush", S_FLUSH, 32'h4);
        push_exp("lw2_stall_a", S_STALL2, 32'h18);
        push_exp("lw2_flush_a", S_FLUSH2, 32'h4);
        settle(); tick(); clr_inputs();

        memtoregM = 1'b1; regwriteM = 1'b1; writeregM = 5'd2; rsD = 5'd2; rsE = 5'd2;
        push_exp("lw1_release", S_STALL, 32'h00);
        push_exp("lw1_fwdE_M", S_FAE, 32'd2);
        push_exp("lw2_stall_b", S_STALL2, 32'h18);
        push_exp("lw2_flush_b", S_FLUSH2, 32'h4);
        push_exp("lw2_fwdD_M", S_FAD2, 32'd1);
        settle(); tick(); clr_inputs();

        regwriteW = 1'b1; writeregW = 5'd2; rsD = 5'd2; rsE = 5'd2;
        push_exp("lw2_release", S_STALL2, 32'h00);
        push_exp("lw2_fwdE_W", S_FAE2, 32'd1);
        settle(); tick(); clr_inputs();

        // Divide: busy 31 cycles, done on cycle 32
        div_startE = 1'b1;
        push_exp("div_start_busy", S_BUSY, 32'd0);
        settle(); tick();
        for (int i = 1; i <= 32; i++) begin
            if (i < 32) begin
                push_exp("div_busy", S_BUSY, 32'd1);
                push_exp("div_nodone", S_DONE, 32'd0);
                push_exp("div_stall", S_STALL, 32'h1C);
            end else begin
                push_exp("div_end_busy", S_BUSY, 32'd0);
                push_exp("div_done", S_DONE, 32'd1);
                push_exp("div_end_stall", S_STALL, 32'h00);
            end
            settle(); tick();
        end
        div_startE = 1'b0;
        push_exp("div_after_done", S_DONE, 32'd0);
        push_exp("div_after_busy", S_BUSY, 32'd0);
        settle(); tick();

        // Exception deferred behind a data-bus stall, latched values used on release
        excepttype = 32'd1; stallreq_from_mem = 1'b1; cp0_epc = 32'h80000010;
        push_exp("excw_nofl", S_FEXC, 32'd0);
        push_exp("excw_stall", S_STALL, 32'h1E);
        push_exp("excw_newpc0", S_NEWPC, 32'd0);
        settle(); tick();
        excepttype = 32'd0; cp0_epc = 32'd0;
        for (int i = 0; i < 2; i++) begin
            push_exp("excw_hold_nofl", S_FEXC, 32'd0);
            push_exp("excw_hold_stall", S_STALL, 32'h1E);
            settle(); tick();
        end
        stallreq_from_mem = 1'b0;
        push_exp("excw_fire", S_FEXC, 32'd1);
        push_exp("excw_newpc", S_NEWPC, 32'hBFC00380);
        push_exp("excw_flush", S_FLUSH, 32'hF);
        push_exp("excw_nostall", S_STALL, 32'h00);
        settle(); tick();
        push_exp("exc_oneshot", S_FEXC, 32'd0);
        push_exp("exc_newpc_clr", S_NEWPC, 32'd0);
        settle(); tick();

        excepttype = 32'h0000000e; cp0_epc = 32'h80001234; stallreq_from_mem = 1'b1;
        push_exp("eretw_nofl", S_FEXC, 32'd0);
        settle(); tick();
        excepttype = 32'd0; cp0_epc = 32'd0; stallreq_from_mem = 1'b0;
        push_exp("eretw_fire", S_FEXC, 32'd1);
        push_exp("eretw_newpc", S_NEWPC, 32'h80001234);
        settle(); tick();

        excepttype = 32'h0000000e; cp0_epc = 32'h80005678;
        push_exp("eret_now", S_FEXC, 32'd1);
        push_exp("eret_now_pc", S_NEWPC, 32'h80005678);
        settle(); tick(); clr_inputs();

        // Exception aborts a divide; a mem stall freezes the count meanwhile
        div_startE = 1'b1;
        settle(); tick();
        for (int i = 1; i <= 10; i++) begin
            stallreq_from_mem = (i == 3) || (i == 4);
            if (i == 10) begin
                excepttype = 32'd1;
                push_exp("divx_fire", S_FEXC, 32'd1);
                push_exp("divx_newpc", S_NEWPC, 32'hBFC00380);
                push_exp("divx_flush", S_FLUSH, 32'hF);
                push_exp("divx_nodone", S_DONE, 32'd0);
            end else if (stallreq_from_mem) begin
                push_exp("divx_mem_busy", S_BUSY, 32'd1);
                push_exp("divx_mem_stall", S_STALL, 32'h1E);
                push_exp("divx_mem_flush", S_FLUSH, 32'h1);
            end else begin
                push_exp("divx_busy", S_BUSY, 32'd1);
            end
            settle(); tick();
        end
        clr_inputs();
        for (int i = 0; i < 3; i++) begin
            push_exp("divx_after_busy", S_BUSY, 32'd0);
            push_exp("divx_after_done", S_DONE, 32'd0);
            settle(); tick();
        end

        // Asynchronous reset in the middle of a divide
        div_startE = 1'b1;
        settle(); tick();
        for (int i = 0; i < 4; i++) begin
            push_exp("divr_busy", S_BUSY, 32'd1);
            settle(); tick();
        end
        #1 rst = 1'b1;
        push_exp("divr_rst_busy", S_BUSY, 32'd0);
        push_exp("divr_rst_stall", S_STALL, 32'h00);
        push_exp("divr_rst_done", S_DONE, 32'd0);
        settle(); tick();
        rst = 1'b0;
        div_startE = 1'b0;
        push_exp("divr_post_busy", S_BUSY, 32'd0);
        push_exp("divr_post_stall", S_STALL, 32'h00);
        settle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
